insn_decode_seq: RTL and testbench
==================================

Name: insn_decode_seq

Overview:
- Second-generation instruction decoder for the control unit. Sits between instruction fetch and the memory/processing/loop dispatchers.
- Adds valid/ready handshaking with a registered output stage.
- Adds a parametrised hardware loop stack for START_LOOP / START_INDEPENDENT_LOOP / END_LOOP, which issues branch requests back to fetch.
- Adds a sticky error status with an error code.

Parameters:
- LOOP_DEPTH, 4, maximum nesting depth of the loop stack (>=1).
- CNT_W, 3, width of the loop iteration field, taken from insn[12 -: CNT_W] (1..10).
- PC_W, 16, width of instruction addresses.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  fetch offers an instruction
- in_ready  output  1  decoder accepts this cycle
- in_insn  input  18  raw instruction; opcode = insn[17:13]
- in_pc  input  PC_W  address of in_insn
- out_valid  output  1  decoded word valid
- out_ready  input  1  dispatcher accepts
- out_type  output  2  00 memory, 01 processing, 10 loop
- out_mem  output  16  memory instruction word
- out_proc  output  16  processing word {unit_onehot[11:0], flags[3:0]}
- out_loop  output  CNT_W+1  {independent, iteration count field}
- br_valid  output  1  one-cycle branch request to fetch
- br_pc  output  PC_W  branch target
- loop_level  output  $clog2(LOOP_DEPTH+1)  current stack occupancy
- error  output  1  sticky error
- err_code  output  2  01 illegal opcode, 10 stack overflow, 11 stack underflow; first error wins

Behaviour:
- Reset: all outputs 0, stack empty, error and err_code cleared. Reset mid-transfer drops everything.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A transfer occurs when in_valid && in_ready.
  - Decoded result is registered: out_valid rises 1 cycle after accept.
  - out_* stay stable while out_valid && !out_ready.
  - out_valid clears on out_ready when there is no new accept.
  - Full throughput when out_ready is held high.
- Non-selected output words are driven 0 on each output load.
- Processing opcodes (out_type 01), listed as unit bit, flags:
  - 0 MATMUL: bit11, 0
  - 1 MULACC: bit10, 0
  - 2 ADD: bit9, 0
  - 3 SUB: bit9, flags 1000
  - 4 MUL: bit10, flags {insn[12],000}
  - 5 DIV: bit8, 0
  - 6 POW: bit7, 0
  - 7 MAX: bit6, flags {insn[12],000}
  - 8 SUM: bit5, flags {insn[12],000}
  - 9 RELU: bit4, 0
  - 10 EXP: bit3, 0
  - 11 LOG: bit2, 0
  - 12 GTZ: bit4, flags 0100
  - 13 COPY: bit1, flags insn[12:9]
  - 14 ZERO: bit0, flags {insn[12:11],00}
- Memory opcodes (out_type 00):
  - 15 LOAD: out_mem = {1,0,insn[12:9],insn[8:7],insn[6:5],insn[4:3],insn[2],insn[1],00}.
  - 16 STORE: out_mem = {1,1,insn[12:9],00,insn[6:5],insn[4:3],0,0,insn[8:7]}.
- Loop opcodes:
  - 17 START_INDEPENDENT_LOOP, 18 START_LOOP:
    - Push {body_pc = in_pc+1 mod 2^PC_W, remaining = field+1} (field 0 means 1 iteration).
    - Emit out_type 10 with out_loop = {opcode==17, field}.
  - 19 END_LOOP emits nothing on out_*:
    - If top remaining > 1: decrement it; br_valid=1 and br_pc=top body_pc in the cycle after accept.
    - Else: pop, no branch.
  - Push when the stack is full: error, code 10; the instruction is dropped with no output and no push.
  - END_LOOP when the stack is empty: error, code 11; dropped.
- Opcodes 20-31: error, code 01; dropped with no output.
- Once error is set, the decoder keeps accepting instructions and keeps decoding legal ones. err_code holds the first error until reset.
- loop_level updates in the cycle after a push/pop.
- br_valid is never asserted on consecutive cycles unless consecutive END_LOOPs are accepted. Fetch is expected to discard in-flight instructions; the decoder does not flush itself.

Optional Feature:
- Macro INSN_DECODE_PERF_CNT_EN.
- When defined: adds outputs perf_insn[31:0] (counts accepted instructions) and perf_stall[31:0] (counts cycles with out_valid && !out_ready). Both are 0 on reset and wrap at 2^32.
- When undefined: the ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ADD (opcode 2) with out_ready=1 -> out_valid=1 next cycle, out_type=01, out_proc=16'h2000, out_mem=0.
- LOAD insn with apu=5, reg=2, h=1, w=3, zero=1, skip=0 -> out_type=00, out_mem={1,0,0101,10,01,11,1,0,00}.
- out_ready=0 for 3 cycles with out_valid high -> in_ready=0, outputs stable, perf_stall=3 when INSN_DECODE_PERF_CNT_EN is defined; release -> next instruction accepted.
- START_LOOP field=2 at pc=0x10, body, END_LOOP fed 3 times -> two br_valid pulses with br_pc=0x11, third END_LOOP pops, loop_level back to 0.
- LOOP_DEPTH=4: five nested START_LOOPs -> 5th raises error, err_code=10, loop_level=4; then END_LOOP x5 -> 5th leaves err_code unchanged at 10.
- Opcode 25 then MATMUL -> error=1, err_code=01, no output for 25, MATMUL output out_proc=16'h8000.

Source files
------------

// File: rtl/insn_decode_seq.sv
// Instruction decoder with a registered valid/ready output stage, a hardware loop stack and sticky error status.
// Optional performance counters (perf_insn, perf_stall) are enabled by defining INSN_DECODE_PERF_CNT_EN.
module insn_decode_seq #(
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 3,
    parameter int PC_W       = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [17:0]                       in_insn,
    input  logic [PC_W-1:0]                   in_pc,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [1:0]                        out_type,
    output logic [15:0]                       out_mem,
    output logic [15:0]                       out_proc,
    output logic [CNT_W:0]                    out_loop,
    output logic                              br_valid,
    output logic [PC_W-1:0]                   br_pc,
    output logic [$clog2(LOOP_DEPTH+1)-1:0]   loop_level,
    output logic                              error,
    output logic [1:0]                        err_code
`ifdef INSN_DECODE_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_insn,
    output logic [31:0]                       perf_stall
`endif
);

    localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam int REM_W = CNT_W + 1;

    logic [PC_W-1:0]  stk_pc_q  [LOOP_DEPTH];
    logic [REM_W-1:0] stk_rem_q [LOOP_DEPTH];
    logic [LVL_W-1:0] level_q, level_d;

    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_type_q;
    logic [15:0]      out_mem_q, out_proc_q;
    logic [CNT_W:0]   out_loop_q;
    logic             br_valid_q;
    logic [PC_W-1:0]  br_pc_q;
    logic             error_q;
    logic [1:0]       err_code_q;

    logic [4:0]       opcode;
    logic [CNT_W-1:0] field;
    logic             accept, stack_full, stack_empty;
    logic [LVL_W-1:0] lvl_m1;
    logic [IDX_W-1:0] top_idx, push_idx;
    logic [REM_W-1:0] top_rem;
    logic             load, push, pop, dec, br_n, err_n;
    logic [1:0]       typ_n, err_code_n;
    logic [15:0]      mem_n;
    logic [11:0]      unit_n;
    logic [3:0]       flags_n;
    logic [CNT_W:0]   loop_n;

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        opcode      = in_insn[17:13];
        field       = in_insn[12 -: CNT_W];
        accept      = in_valid && in_ready;
        lvl_m1      = level_q - LVL_W'(1);
        top_idx     = lvl_m1[IDX_W-1:0];
        push_idx    = level_q[IDX_W-1:0];
        top_rem     = stk_rem_q[top_idx];
        stack_full  = (level_q == LVL_W'(LOOP_DEPTH));
        stack_empty = (level_q == '0);

        load       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        dec        = 1'b0;
        br_n       = 1'b0;
        err_n      = 1'b0;
        err_code_n = 2'b00;
        typ_n      = 2'b00;
        mem_n      = '0;
        unit_n     = '0;
        flags_n    = '0;
        loop_n     = '0;

        if (accept) begin
            case (opcode)
                5'd0:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h800; end
                5'd1:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h400; end
                5'd2:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h200; end
                5'd3:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h200; flags_n = 4'b1000; end
                5'd4:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h400; flags_n = {in_insn[12], 3'b000}; end
                5'd5:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h100; end
                5'd6:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h080; end
                5'd7:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h040; flags_n = {in_insn[12], 3'b000}; end
                5'd8:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h020; flags_n = {in_insn[12], 3'b000}; end
                5'd9:  begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h010; end
                5'd10: begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h008; end
                5'd11: begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h004; end
                5'd12: begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h010; flags_n = 4'b0100; end
                5'd13: begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h002; flags_n = in_insn[12:9]; end
                5'd14: begin load = 1'b1; typ_n = 2'b01; unit_n = 12'h001; flags_n = {in_insn[12:11], 2'b00}; end
                5'd15: begin
                    load  = 1'b1;
                    mem_n = {2'b10, in_insn[12:9], in_insn[8:7], in_insn[6:5], in_insn[4:3],
                             in_insn[2], in_insn[1], 2'b00};
                end
                5'd16: begin
                    load  = 1'b1;
                    mem_n = {2'b11, in_insn[12:9], 2'b00, in_insn[6:5], in_insn[4:3],
                             2'b00, in_insn[8:7]};
                end
                5'd17, 5'd18: begin
                    if (stack_full) begin
                        err_n      = 1'b1;
                        err_code_n = 2'b10;
                    end else begin
                        load   = 1'b1;
                        push   = 1'b1;
                        typ_n  = 2'b10;
                        loop_n = {(opcode == 5'd17), field};
                    end
                end
                5'd19: begin
                    if (stack_empty) begin
                        err_n      = 1'b1;
                        err_code_n = 2'b11;
                    end else if (top_rem > REM_W'(1)) begin
                        dec  = 1'b1;
                        br_n = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
                default: begin
                    err_n      = 1'b1;
                    err_code_n = 2'b01;
                end
            endcase
        end

        // An accept without a load implies the old word was consumed or absent.
        if (load)           out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;

        if (push)     level_d = level_q + LVL_W'(1);
        else if (pop) level_d = lvl_m1;
        else          level_d = level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_mem_q   <= '0;
            out_proc_q  <= '0;
            out_loop_q  <= '0;
            br_valid_q  <= 1'b0;
            br_pc_q     <= '0;
            level_q     <= '0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                stk_pc_q[i]  <= '0;
                stk_rem_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            level_q     <= level_d;
            br_valid_q  <= br_n;
            if (load) begin
                out_type_q <= typ_n;
                out_mem_q  <= mem_n;
                out_proc_q <= {unit_n, flags_n};
                out_loop_q <= loop_n;
            end
            if (br_n) br_pc_q <= stk_pc_q[top_idx];
            if (push) begin
                stk_pc_q[push_idx]  <= in_pc + PC_W'(1);
                stk_rem_q[push_idx] <= REM_W'(field) + REM_W'(1);
            end
            if (dec) stk_rem_q[top_idx] <= top_rem - REM_W'(1);
            if (err_n && !error_q) begin
                error_q    <= 1'b1;
                err_code_q <= err_code_n;
            end
        end
    end

`ifdef INSN_DECODE_PERF_CNT_EN
    logic [31:0] perf_insn_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_insn_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept)                     perf_insn_q  <= perf_insn_q + 32'd1;
            if (out_valid_q && !out_ready)  perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_insn  = perf_insn_q;
    assign perf_stall = perf_stall_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_type   = out_type_q;
    assign out_mem    = out_mem_q;
    assign out_proc   = out_proc_q;
    assign out_loop   = out_loop_q;
    assign br_valid   = br_valid_q;
    assign br_pc      = br_pc_q;
    assign loop_level = level_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_insn_decode_seq.sv
// Directed bench for insn_decode_seq: decode table plus handshake, loop-stack and error sequences.
module tb_insn_decode_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_insn;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_type;
    logic [15:0] out_mem;
    logic [15:0] out_proc;
    logic [3:0]  out_loop;
    logic        br_valid;
    logic [15:0] br_pc;
    logic [2:0]  loop_level;
    logic        error;
    logic [1:0]  err_code;
`ifdef INSN_DECODE_PERF_CNT_EN
    logic [31:0] perf_insn;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    insn_decode_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_insn    (in_insn),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_mem    (out_mem),
        .out_proc   (out_proc),
        .out_loop   (out_loop),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .loop_level (loop_level),
        .error      (error),
        .err_code   (err_code)
`ifdef INSN_DECODE_PERF_CNT_EN
        ,
        .perf_insn  (perf_insn),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] insn;
        logic [1:0]  typ;
        logic [15:0] mem;
        logic [15:0] proc;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [17:0] mk(input logic [4:0] op, input logic [12:0] low);
        return {op, low};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst error", 32'(error), 32'd0);
        chk("rst err_code", 32'(err_code), 32'd0);
        chk("rst loop_level", 32'(loop_level), 32'd0);
        chk("rst br_valid", 32'(br_valid), 32'd0);
        chk("rst out_proc", 32'(out_proc), 32'd0);
    endtask

    // Offers one instruction for a single cycle; outputs are sampled 1ns after the accepting edge.
    task automatic send(input logic [17:0] insn, input logic [15:0] pc);
        @(negedge clk);
        in_valid = 1'b1;
        in_insn  = insn;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_insn   = '0;
        in_pc     = '0;
        out_ready = 1'b1;

        tbl[0] = '{mk(5'd2,  13'h0000), 2'b01, 16'h0000, 16'h2000};
        tbl[1] = '{mk(5'd3,  13'h0000), 2'b01, 16'h0000, 16'h2008};
        tbl[2] = '{mk(5'd4,  13'h1000), 2'b01, 16'h0000, 16'h4008};
        tbl[3] = '{mk(5'd7,  13'h0000), 2'b01, 16'h0000, 16'h0400};
        tbl[4] = '{mk(5'd12, 13'h0000), 2'b01, 16'h0000, 16'h0104};
        tbl[5] = '{mk(5'd13, 13'h1600), 2'b01, 16'h0000, 16'h002B};
        tbl[6] = '{mk(5'd14, 13'h1000), 2'b01, 16'h0000, 16'h0018};
        tbl[7] = '{mk(5'd11, 13'h0000), 2'b01, 16'h0000, 16'h0040};
        tbl[8] = '{mk(5'd15, 13'h0B3C), 2'b00, 16'h9678, 16'h0000};
        tbl[9] = '{mk(5'd16, 13'h0B3C), 2'b00, 16'hD472, 16'h0000};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].insn, 16'(i));
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d type", i), 32'(out_type), 32'(tbl[i].typ));
            chk($sformatf("vec%0d mem", i), 32'(out_mem), 32'(tbl[i].mem));
            chk($sformatf("vec%0d proc", i), 32'(out_proc), 32'(tbl[i].proc));
            chk($sformatf("vec%0d loop", i), 32'(out_loop), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: ADD held in the output stage for three stalled cycles.
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = mk(5'd2, 13'h0);
        @(posedge clk);
        #1;
        chk("stall first valid", 32'(out_valid), 32'd1);
        in_insn = mk(5'd3, 13'h0);
        for (int c = 0; c < 3; c++) begin
            chk("stall in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("stall proc stable", 32'(out_proc), 32'h2000);
            chk("stall valid held", 32'(out_valid), 32'd1);
        end
`ifdef INSN_DECODE_PERF_CNT_EN
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_insn", perf_insn, 32'd1);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release next proc", 32'(out_proc), 32'h2008);
        chk("release next valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("release drained", 32'(out_valid), 32'd0);

        // Loop of three iterations: two branches back to the body, then a pop.
        send(mk(5'd18, 13'h0800), 16'h0010);
        chk("loop type", 32'(out_type), 32'd2);
        chk("loop word", 32'(out_loop), 32'h2);
        chk("loop mem zero", 32'(out_mem), 32'd0);
        chk("loop proc zero", 32'(out_proc), 32'd0);
        chk("loop level push", 32'(loop_level), 32'd1);
        send(mk(5'd2, 13'h0), 16'h0011);
        for (int k = 0; k < 3; k++) begin
            send(mk(5'd19, 13'h0), 16'h0012);
            chk($sformatf("end%0d no output", k), 32'(out_valid), 32'd0);
            chk($sformatf("end%0d br_valid", k), 32'(br_valid), (k < 2) ? 32'd1 : 32'd0);
            if (k < 2) chk($sformatf("end%0d br_pc", k), 32'(br_pc), 32'h0011);
        end
        chk("loop level pop", 32'(loop_level), 32'd0);
        chk("loop no error", 32'(error), 32'd0);
        send(mk(5'd17, 13'h1400), 16'h0020);
        chk("indep loop word", 32'(out_loop), 32'hD);
        send(mk(5'd19, 13'h0), 16'h0021);
        chk("indep end br", 32'(br_valid), 32'd1);
        chk("indep end br_pc", 32'(br_pc), 32'h0021);

        // Reset while an output word is stalled drops it and empties the stack.
        @(negedge clk);
        out_ready = 1'b0;
        send(mk(5'd0, 13'h0), 16'h0);
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        do_reset();

        // Overflow then underflow: the first error code must stick.
        for (int k = 0; k < 5; k++) send(mk(5'd18, 13'h0), 16'(k));
        chk("ovf error", 32'(error), 32'd1);
        chk("ovf err_code", 32'(err_code), 32'd2);
        chk("ovf loop_level", 32'(loop_level), 32'd4);
        chk("ovf dropped", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) send(mk(5'd19, 13'h0), 16'h0);
        chk("unf loop_level", 32'(loop_level), 32'd0);
        chk("unf err_code", 32'(err_code), 32'd2);
        chk("unf br_valid", 32'(br_valid), 32'd0);

        // Illegal opcode, then decoding carries on.
        do_reset();
        send(mk(5'd25, 13'h0), 16'h0);
        chk("ill error", 32'(error), 32'd1);
        chk("ill err_code", 32'(err_code), 32'd1);
        chk("ill dropped", 32'(out_valid), 32'd0);
        send(mk(5'd0, 13'h0), 16'h1);
        chk("post-err valid", 32'(out_valid), 32'd1);
        chk("post-err type", 32'(out_type), 32'd1);
        chk("post-err proc", 32'(out_proc), 32'h8000);
        send(mk(5'd19, 13'h0), 16'h2);
        chk("post-err code held", 32'(err_code), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
